// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the execute stage.
// Stalls the pipeline while iterating and presents a one-cycle result strobe.
module ex_div #(
  parameter int CPU_WIDTH = 32,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [CPU_WIDTH-1:0] dividend_i,
  input  logic [CPU_WIDTH-1:0] divisor_i,
  input  logic [4:0]           reg_wr_adder_i,
  input  logic                 flush_i,
  output logic [CPU_WIDTH-1:0] result_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic                 stall_req_o,
  output logic [4:0]           reg_wr_adder_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [1:0]           OP_DIV   = 2'b00;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CPU_WIDTH - 1);
  localparam logic [CPU_WIDTH-1:0] MIN_NEG  = {1'b1, {(CPU_WIDTH-1){1'b0}}};

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CPU_WIDTH-1:0] rem_q, rem_d;
  logic [CPU_WIDTH-1:0] quo_q, quo_d;
  logic [CPU_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CPU_WIDTH-1:0] result_q, result_d;
  logic [4:0]           rd_q, rd_d;
  logic                 op_rem_q, op_rem_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;

  logic                 dvd_neg, dvs_neg;
  logic [CPU_WIDTH-1:0] dvd_abs, dvs_abs;
  logic [CPU_WIDTH:0]   rem_sh;
  logic [CPU_WIDTH-1:0] rem_sub, rem_step, quo_step;
  logic                 trial_ok;

  // Operand magnitudes; unsigned ops (op_i[0]=1) pass raw values through.
  assign dvd_neg = ~op_i[0] & dividend_i[CPU_WIDTH-1];
  assign dvs_neg = ~op_i[0] & divisor_i[CPU_WIDTH-1];
  assign dvd_abs = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_abs = dvs_neg ? -divisor_i : divisor_i;

  // One restoring step: the partial remainder needs one extra bit before the trial subtract.
  assign rem_sh   = {rem_q, quo_q[CPU_WIDTH-1]};
  assign trial_ok = rem_sh >= {1'b0, dvsr_q};
  assign rem_sub  = rem_sh[CPU_WIDTH-1:0] - dvsr_q;
  assign rem_step = trial_ok ? rem_sub : rem_sh[CPU_WIDTH-1:0];
  assign quo_step = {quo_q[CPU_WIDTH-2:0], trial_ok};

  always_comb begin
    // NOTE: every _d defaults to its _q first so no branch of the case below infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;
    rd_d      = rd_q;
    op_rem_d  = op_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          op_rem_d  = op_i[1];
          rd_d      = reg_wr_adder_i;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          rem_d     = '0;
          quo_d     = dvd_abs;
          dvsr_d    = dvs_abs;
          cnt_d     = '0;
          if (divisor_i == '0) begin
            state_d  = DONE;
            result_d = op_i[1] ? dividend_i : '1;
          end else if (op_i == OP_DIV && dividend_i == MIN_NEG && divisor_i == '1) begin
            state_d  = DONE;
            result_d = MIN_NEG;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = op_rem_q ? (neg_rem_q ? -rem_step : rem_step)
                              : (neg_quo_q ? -quo_step : quo_step);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A killed instruction must not disturb the visible result.
    if (flush_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      op_rem_q  <= op_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign stall_req_o    = (state_q == IDLE && start_i && !flush_i) || state_q == CALC;
  assign done_o         = state_q == DONE;
  assign busy_o         = state_q != IDLE;
  assign result_o       = result_q;
  assign reg_wr_adder_o = rd_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: latency, signed fix-up, fast paths,
// flush, mid-operation reset and ignored re-starts.
module tb_ex_div;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  reg_wr_adder_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] result_o;
  logic        done_o;
  logic        busy_o;
  logic        stall_req_o;
  logic [4:0]  reg_wr_adder_o;

  int checks = 0;
  int failures = 0;

  ex_div #(.CPU_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .op_i           (op_i),
    .dividend_i     (dividend_i),
    .divisor_i      (divisor_i),
    .reg_wr_adder_i (reg_wr_adder_i),
    .flush_i        (flush_i),
    .result_o       (result_o),
    .done_o         (done_o),
    .busy_o         (busy_o),
    .stall_req_o    (stall_req_o),
    .reg_wr_adder_o (reg_wr_adder_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives a request just after a rising edge; that cycle is cycle 0.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_wr_adder_i = rd;
  endtask

  // Returns the cycle of done_o (-1 on timeout) and whether stall_req_o was high before it.
  task automatic wait_done(output int lat, output logic stall_all);
    lat = -1;
    stall_all = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done_o) begin
        lat = c;
        break;
      end
      if (!stall_req_o) stall_all = 1'b0;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
  endtask

  task automatic next_cycle_idle(input string tag);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check({tag, "_busy_after"}, busy_o, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int   lat;
    logic stall_all;
    issue(op, a, b, rd);
    wait_done(lat, stall_all);
    if (exp_lat >= 0) check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_rd"}, reg_wr_adder_o, rd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic stall_all;
    logic saw_done;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_result", result_o, 32'h0);
    check("rst_done", done_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_stall", stall_req_o, 1'b0);
    check("rst_rd", reg_wr_adder_o, 5'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // DIVU 100/7 with full latency and stall profile
    issue(OP_DIVU, 32'd100, 32'd7, 5'd5);
    wait_done(lat, stall_all);
    check("divu_lat", lat, 33);
    check("divu_stall_calc", stall_all, 1'b1);
    check("divu_stall_done", stall_req_o, 1'b0);
    check("divu_res", result_o, 32'd14);
    check("divu_rd", reg_wr_adder_o, 5'd5);
    next_cycle_idle("divu");
    check("divu_hold", result_o, 32'd14);

    // Signed remainder / quotient sign fix
    run_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33);
    run_op("div_negdvs", OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd8, 32'hFFFF_FFF2, 33);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd9, 32'd1, 33);

    // Divide by zero fast path
    run_op("div_zero", OP_DIV, 32'd1234, 32'd0, 5'd10, 32'hFFFF_FFFF, 1);
    next_cycle_idle("div_zero");
    run_op("remu_zero", OP_REMU, 32'd1234, 32'd0, 5'd11, 32'd1234, 1);
    run_op("rem_zero", OP_REM, 32'hFFFF_FFF9, 32'd0, 5'd12, 32'hFFFF_FFF9, 1);

    // Signed overflow
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0, -1);
    next_cycle_idle("rem_ovf");

    // Flush at cycle 10, restart at cycle 12 (done at absolute cycle 45)
    saw_done = 1'b0;
    issue(OP_DIVU, 32'd1000, 32'd10, 5'd15);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      flush_i = (c == 10);
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
      if (c == 11) check("flush_busy", busy_o, 1'b0);
    end
    flush_i = 1'b0;
    check("flush_no_done", saw_done, 1'b0);
    issue(OP_DIVU, 32'd1000, 32'd10, 5'd16);
    wait_done(lat, stall_all);
    check("flush_restart_lat", lat, 33);
    check("flush_restart_res", result_o, 32'd100);
    check("flush_restart_rd", reg_wr_adder_o, 5'd16);

    // Reset in the middle of CALC (cycle 20)
    issue(OP_DIVU, 32'd100, 32'd7, 5'd17);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_done", done_o, 1'b0);
    check("midrst_result", result_o, 32'h0);
    check("midrst_rd", reg_wr_adder_o, 5'd0);
    check("midrst_stall", stall_req_o, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op("after_rst", OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 33);
    next_cycle_idle("after_rst");

    // start_i toggled with new operands during CALC and in DONE is ignored
    lat = -1;
    issue(OP_DIVU, 32'd200, 32'd9, 5'd7);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start_i = (c <= 33) ? c[0] : 1'b0;
      op_i = OP_DIV; dividend_i = 32'd5; divisor_i = 32'd1; reg_wr_adder_i = 5'd9;
      @(negedge clk);
      if (done_o) begin
        lat = c;
        break;
      end
    end
    check("toggle_lat", lat, 33);
    check("toggle_res", result_o, 32'd22);
    check("toggle_rd", reg_wr_adder_o, 5'd7);
    next_cycle_idle("toggle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative radix-2 divider in the execute stage, downstream of the ID/EX pipeline register.
- Consumes the decoded RV32M DIV/DIVU/REM/REMU operation and both register operands.
- Requests a pipeline stall while it computes, then presents a one-cycle result to the EX result mux.
- Flow control holds the ID/EX register (FLOW_STOP) while stall_req_o is high.

Parameters:
CPU_WIDTH, 32, operand/result width (must be power of two, >=8)
CNT_WIDTH, 5, iteration counter width, = log2(CPU_WIDTH)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start_i  input  1  divide request from EX decode (alu_op is a div/rem op and instruction valid)
op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
dividend_i  input  CPU_WIDTH  rs1 value
divisor_i  input  CPU_WIDTH  rs2 value
reg_wr_adder_i  input  5  destination register of the request
flush_i  input  1  pipeline refresh (branch/jump/trap kill)
result_o  output  CPU_WIDTH  quotient or remainder, valid when done_o=1
done_o  output  1  one-cycle result-valid strobe
busy_o  output  1  state != IDLE
stall_req_o  output  1  stall request to flow control
reg_wr_adder_o  output  5  latched destination register, valid with done_o

Behaviour:
- Reset: asynchronous, active-low. State IDLE, counter 0, internal remainder/quotient/operand regs 0. Outputs: result_o=0, reg_wr_adder_o=0, done_o=0, busy_o=0. stall_req_o=0 while start_i=0.
- States:
  - IDLE: waiting for start_i.
  - CALC: iterating.
  - DONE: present result for one cycle.
- IDLE transitions, on start_i=1 && flush_i=0:
  - latch op, reg_wr_adder, sign info, |dividend|, |divisor|;
  - divisor==0 -> DONE with fast result;
  - op DIV && dividend==0x80000000 && divisor==0xFFFFFFFF -> DONE with fast result;
  - otherwise -> CALC, counter=0.
- CALC: one restoring step per clock on magnitudes.
  - Shift {rem,quo} left 1.
  - Trial subtract divisor from rem; if non-negative, commit and set quo LSB=1.
  - counter increments; after the step with counter==CPU_WIDTH-1 -> DONE.
- DONE: done_o=1 for exactly one cycle, then -> IDLE.
- Sign fix for DIV/REM, registered on the transition into DONE:
  - quotient negated if sign(dividend)^sign(divisor);
  - remainder negated if sign(dividend).
- Unsigned ops use raw operands.
- Fast results (RISC-V spec):
  - divide by zero: quotient = all ones, remainder = dividend (all four ops);
  - signed overflow: quotient = 0x80000000, remainder = 0.
- result_o selects quotient for DIV/DIVU, remainder for REM/REMU. It holds its last value outside DONE (no clear).
- Latency:
  - normal: start_i high in cycle 0 -> done_o high in cycle CPU_WIDTH+1 (33);
  - fast path: start_i in cycle 0 -> done_o in cycle 1.
- stall_req_o = (state==IDLE && start_i && !flush_i) || state==CALC. It is combinational and low in the DONE cycle so the pipeline advances and captures result_o.
- start_i while busy: ignored. The stalled pipeline re-presents the same instruction, and the latched operands are used.
- A new start_i in the DONE cycle is ignored. The instruction seen then belongs to the next pipeline slot, which is only presented after IDLE.
- flush_i in any state:
  - next state IDLE, no done_o, counter cleared;
  - flush wins over start_i in the same cycle;
  - flush in the DONE cycle still suppresses nothing (done_o already high). State -> IDLE as normal.
- Reset mid-CALC: immediate return to IDLE, all outputs per reset values.
- Counter wrap: never wraps. Exit is decoded at CPU_WIDTH-1.

Test Plan:
- DIVU 100/7, rd=5: start cycle 0 -> stall_req_o high cycles 0-32; done_o cycle 33 with result_o=14, reg_wr_adder_o=5; busy_o low cycle 34.
- REM -7 (0xFFFFFFF9) by 2 -> result_o=0xFFFFFFFF (-1) at cycle 33. DIV same operands -> 0xFFFFFFFD (-3).
- Divide by zero, DIV 1234/0 -> done_o cycle 1, result 0xFFFFFFFF. REMU 1234/0 -> 1234.
- DIV 0x80000000/0xFFFFFFFF -> done_o cycle 1, result 0x80000000. REM same operands -> 0.
- flush_i asserted cycle 10 of a DIVU -> IDLE cycle 11, done_o never pulses. New start in cycle 12 completes correctly at cycle 45.
- rst_n low at cycle 20 of CALC -> outputs zero immediately. Start after release behaves normally. start_i toggled with new operands during CALC -> ignored, original result returned.
